// File: rtl/step_pulse_gen.sv
// rtl/step_pulse_gen.sv - STEP/DIR pulse generator with DIR setup, STEP high/low timing and position tracking
module step_pulse_gen #(
  parameter int PULSE_HIGH = 20,
  parameter int PULSE_LOW  = 20,
  parameter int DIR_SETUP  = 10,
  parameter int POS_WIDTH  = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 req_in,
  input  logic                 dir_in,
  output logic                 r_ready,
  output logic                 r_step,
  output logic                 r_dir,
  output logic [POS_WIDTH-1:0] r_position
);

  // One counter serves every timed state, so it is sized for the longest interval.
  localparam int MAX_HL = (PULSE_HIGH > PULSE_LOW) ? PULSE_HIGH : PULSE_LOW;
  localparam int MAX_P  = (MAX_HL > DIR_SETUP) ? MAX_HL : DIR_SETUP;
  localparam int CNT_W  = $clog2(MAX_P) + 1;

  // Terminal counts: each state lasts exactly N edges, counting 0..N-1.
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(DIR_SETUP - 1);
  localparam logic [CNT_W-1:0] HIGH_LAST  = CNT_W'(PULSE_HIGH - 1);
  localparam logic [CNT_W-1:0] LOW_LAST   = CNT_W'(PULSE_LOW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   ready_q;
  logic                   step_q;
  logic                   dir_q;
  logic [POS_WIDTH-1:0]   pos_q;
  logic [POS_WIDTH-1:0]   pos_up_d;
  logic [POS_WIDTH-1:0]   pos_dn_d;

  // Candidate next positions; the position moves only on the edge STEP rises.
  always_comb begin
    pos_up_d = pos_q + POS_WIDTH'(1);
    pos_dn_d = pos_q - POS_WIDTH'(1);
  end

  // Step sequencer: accept, optional DIR setup wait, STEP high, STEP low recovery.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      pos_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_in && ready_q) begin
            ready_q <= 1'b0;
            dir_q   <= dir_in;
            cnt_q   <= '0;
            if (dir_in == dir_q) begin
              // DIR already settled: STEP can rise on the accept edge itself.
              step_q  <= 1'b1;
              pos_q   <= dir_in ? pos_up_d : pos_dn_d;
              state_q <= HIGH;
            end else begin
              state_q <= SETUP;
            end
          end
        end
        SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            step_q  <= 1'b1;
            pos_q   <= dir_q ? pos_up_d : pos_dn_d;
            cnt_q   <= '0;
            state_q <= HIGH;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HIGH: begin
          if (cnt_q == HIGH_LAST) begin
            step_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= LOW;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        LOW: begin
          // The ready edge adds one more low cycle before the next accept can raise STEP.
          if (cnt_q == LOW_LAST) begin
            ready_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          ready_q <= 1'b1;
          step_q  <= 1'b0;
        end
      endcase
    end
  end

  assign r_ready    = ready_q;
  assign r_step     = step_q;
  assign r_dir      = dir_q;
  assign r_position = pos_q;

endmodule
